// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: write-back select codes, FSM states,
// abort-hold length and the write-back data selector.
package mem_stage_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_DM  = 2'b01;
    localparam logic [1:0] WB_NPC = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Cycles (abort cycle included) during which dm_req/stall_o stay low after a timeout
    localparam logic [1:0] ABORT_HOLD = 2'd2;

    function automatic logic [31:0] wb_select(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] dm,
        input logic [31:0] npc
    );
        logic [31:0] data;
        case (sel)
            WB_ALU:  data = alu;
            WB_DM:   data = dm;
            WB_NPC:  data = npc;
            default: data = alu;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: inserts a bubble while stalled or when the
// instruction is dropped, otherwise captures the retiring result.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_drop,
    input  logic        i_write,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    output logic        o_write,
    output logic [4:0]  o_waddr,
    output logic [31:0] o_wdata
);

    // Result capture; destination and data hold whenever nothing retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_write <= 1'b0;
            o_waddr <= 5'd0;
            o_wdata <= 32'd0;
        end else if (i_stall || i_drop) begin
            o_write <= 1'b0;
        end else begin
            o_write <= i_write;
            o_waddr <= i_waddr;
            o_wdata <= i_wdata;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory handshake, upstream stall, error reporting
// and MEM/WB register. Optional access timeout enabled by MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_w_MEM,
    input  logic              write_MEM,
    input  logic [4:0]        waddr_MEM,
    input  logic [1:0]        mux_wdata_MEM,
    input  logic [31:0]       alu_MEM,
    input  logic [31:0]       npc_MEM,
    input  logic [31:0]       DM_wdata_MEM,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic              stall_o,
    output logic              write_WB,
    output logic [4:0]        waddr_WB,
    output logic [31:0]       wdata_WB,
    output logic              misalign_err,
    output logic [31:0]       err_addr,
    output logic [31:0]       stall_cnt,
    output logic              timeout_err
);

`ifdef MEM_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif
    // Abort fires in the WAIT cycle whose count completes TIMEOUT_CYCLES waits
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_e  r_state;
    mem_state_e  w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [1:0]  r_hold_cnt;
    logic        r_misal_err;
    logic        r_timeout_err;
    logic [31:0] r_err_addr;
    logic [31:0] r_stall_cnt;

    logic        w_need_acc;
    logic        w_misal;
    logic        w_abort;
    logic        w_hold;
    logic        w_req;
    logic        w_stall;
    logic [31:0] w_wb_data;

    // Request, misalignment, abort and stall decode
    always_comb begin
        w_need_acc = DM_w_MEM | (mux_wdata_MEM == WB_DM);
        w_misal    = w_need_acc & (alu_MEM[1:0] != 2'b00);
        w_abort    = TIMEOUT_EN & (r_state == WAIT) & (r_wait_cnt == TO_LAST);
        w_hold     = w_abort | (r_hold_cnt != 2'd0);
        w_req      = rst & w_need_acc & ~w_misal & ~w_hold;
        w_stall    = w_req & ~dm_ack;
        w_wb_data  = wb_select(mux_wdata_MEM, alu_MEM, dm_rdata, npc_MEM);
    end

    // Next-state logic for the access FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_stall) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (w_abort || (w_req && dm_ack)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter (zero on the first WAIT cycle) and post-abort hold counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
            r_hold_cnt <= 2'd0;
        end else begin
            if (r_state == IDLE) begin
                r_wait_cnt <= 8'd0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_abort) begin
                r_hold_cnt <= ABORT_HOLD - 2'd1;
            end else if (r_hold_cnt != 2'd0) begin
                r_hold_cnt <= r_hold_cnt - 2'd1;
            end else begin
                r_hold_cnt <= 2'd0;
            end
        end
    end

    // Error pulses, captured error address and saturating stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misal_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_err_addr    <= 32'd0;
            r_stall_cnt   <= 32'd0;
        end else begin
            r_misal_err   <= ~w_stall & w_misal;
            r_timeout_err <= w_abort;
            if ((~w_stall & w_misal) | w_abort) begin
                r_err_addr <= alu_MEM;
            end else begin
                r_err_addr <= r_err_addr;
            end
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .rst_n   (rst),
        .i_stall (w_stall),
        .i_drop  (w_misal | w_abort),
        .i_write (write_MEM),
        .i_waddr (waddr_MEM),
        .i_wdata (w_wb_data),
        .o_write (write_WB),
        .o_waddr (waddr_WB),
        .o_wdata (wdata_WB)
    );

    assign dm_req       = w_req;
    assign dm_we        = DM_w_MEM;
    assign dm_addr      = alu_MEM[ADDR_W-1:0];
    assign dm_wdata     = DM_wdata_MEM;
    assign stall_o      = w_stall;
    assign misalign_err = r_misal_err;
    assign timeout_err  = r_timeout_err;
    assign err_addr     = r_err_addr;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage; the timeout scenario is
// exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        DM_w_MEM, write_MEM;
    logic [4:0]  waddr_MEM;
    logic [1:0]  mux_wdata_MEM;
    logic [31:0] alu_MEM, npc_MEM, DM_wdata_MEM;
    logic        dm_req, dm_we, dm_ack, stall_o;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        write_WB, misalign_err, timeout_err;
    logic [4:0]  waddr_WB;
    logic [31:0] wdata_WB, err_addr, stall_cnt;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .DM_w_MEM(DM_w_MEM), .write_MEM(write_MEM),
        .waddr_MEM(waddr_MEM), .mux_wdata_MEM(mux_wdata_MEM), .alu_MEM(alu_MEM),
        .npc_MEM(npc_MEM), .DM_wdata_MEM(DM_wdata_MEM), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .stall_o(stall_o), .write_WB(write_WB),
        .waddr_WB(waddr_WB), .wdata_WB(wdata_WB), .misalign_err(misalign_err),
        .err_addr(err_addr), .stall_cnt(stall_cnt), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        write;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        merr;
        logic [31:0] eaddr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        mon_en  = 1'b0;
    logic        pend    = 1'b0;
    logic [4:0]  m_waddr = 5'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_eaddr = 32'd0;
    logic [31:0] m_stalls = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every edge taken without a stall retires one instruction
    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: retire seen, expected no retire at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_WB", 32'(write_WB), 32'(mon_e.write));
                check("waddr_WB", 32'(waddr_WB), 32'(mon_e.waddr));
                check("wdata_WB", wdata_WB, mon_e.wdata);
                check("misalign_err", 32'(misalign_err), 32'(mon_e.merr));
                check("err_addr", err_addr, mon_e.eaddr);
                check("timeout_err", 32'(timeout_err), 32'd0);
            end
        end
        pend = mon_en && !stall_o;
    end

    task automatic set_bubble();
        DM_w_MEM = 1'b0; write_MEM = 1'b0; waddr_MEM = 5'd0; mux_wdata_MEM = 2'b00;
        alu_MEM = 32'd0; npc_MEM = 32'd0; DM_wdata_MEM = 32'd0; dm_ack = 1'b0;
        dm_rdata = 32'd0;
    endtask

    // Drive one instruction; memory acks after lat cycles. Called at posedge+1.
    task automatic issue(input logic dmw, input logic wr, input logic [4:0] wa,
                         input logic [1:0] mux, input logic [31:0] alu,
                         input logic [31:0] npc, input logic [31:0] sd,
                         input logic [31:0] rd, input int lat_in);
        exp_t        e;
        logic        need, mis, acc;
        logic [31:0] wd;
        int          lat;
        need = dmw || (mux == 2'b01);
        mis  = need && (alu[1:0] != 2'b00);
        acc  = need && !mis;
        lat  = acc ? lat_in : 0;
        if (mis) begin
            m_eaddr = alu;
            e = '{write: 1'b0, waddr: m_waddr, wdata: m_wdata, merr: 1'b1, eaddr: m_eaddr};
        end else begin
            wd = (mux == 2'b01) ? rd : (mux == 2'b10) ? npc : alu;
            m_waddr = wa;
            m_wdata = wd;
            e = '{write: wr, waddr: wa, wdata: wd, merr: 1'b0, eaddr: m_eaddr};
        end
        exp_q.push_back(e);
        DM_w_MEM = dmw; write_MEM = wr; waddr_MEM = wa; mux_wdata_MEM = mux;
        alu_MEM = alu; npc_MEM = npc; DM_wdata_MEM = sd;
        for (int c = 0; c <= lat; c++) begin
            dm_ack   = acc ? (c == lat) : 1'($urandom_range(0, 1));
            dm_rdata = (acc && c == lat) ? rd : $urandom;
            #1;
            check("dm_req", 32'(dm_req), 32'(acc));
            check("stall_o", 32'(stall_o), 32'(acc && c < lat));
            if (acc) begin
                check("dm_we", 32'(dm_we), 32'(dmw));
                check("dm_addr", dm_addr, alu);
                check("dm_wdata", dm_wdata, sd);
            end
            @(posedge clk); #1;
        end
        m_stalls = m_stalls + 32'(lat);
    endtask

    task automatic drain();
        set_bubble();
        mon_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        check("stall_cnt", stall_cnt, m_stalls);
        @(posedge clk); #1;
    endtask

    task automatic random_instr();
        int          kind;
        logic [31:0] a;
        kind = $urandom_range(0, 5);
        a    = $urandom & 32'hFFFF_FFFC;
        case (kind)
            0: issue(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 0);
            1: issue(1'b0, 1'b1, 5'($urandom), (($urandom % 2) == 0) ? 2'b00 : 2'b11,
                     $urandom, $urandom, $urandom, $urandom, 0);
            2: issue(1'b0, 1'b1, 5'($urandom), 2'b10, $urandom, $urandom, $urandom, $urandom, 0);
            3: issue(1'b0, 1'b1, 5'($urandom), 2'b01, a, $urandom, $urandom, $urandom,
                     $urandom_range(0, 4));
            4: issue(1'b1, 1'($urandom), 5'($urandom), (($urandom % 2) == 0) ? 2'b00 : 2'b10,
                     a, $urandom, $urandom, $urandom, $urandom_range(0, 4));
            default: issue((($urandom % 2) == 0), 1'b1, 5'($urandom),
                           (($urandom % 2) == 0) ? 2'b01 : 2'b00,
                           a | 32'($urandom_range(1, 3)), $urandom, $urandom, $urandom, 2);
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        set_bubble();
        mux_wdata_MEM = 2'b01;
        alu_MEM = 32'h100;
        dm_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_dm_req", 32'(dm_req), 32'd0);
        check("rst_write_WB", 32'(write_WB), 32'd0);
        check("rst_wdata_WB", wdata_WB, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_misalign_err", 32'(misalign_err), 32'd0);
        @(negedge clk);
        set_bubble();
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        issue(1'b0, 1'b1, 5'd8, 2'b01, 32'h100, 32'd0, 32'd0, 32'hDEAD_BEEF, 0);
        check("zero_stall_cnt", stall_cnt, 32'd0);
        issue(1'b1, 1'b0, 5'd0, 2'b00, 32'h200, 32'd0, 32'h1234_5678, 32'd0, 3);
        check("sw_stall_cnt", stall_cnt, 32'd3);
        issue(1'b0, 1'b1, 5'd5, 2'b01, 32'h102, 32'd0, 32'd0, 32'h5555_AAAA, 0);
        issue(1'b0, 1'b1, 5'd3, 2'b00, 32'h55, 32'd0, 32'd0, 32'd0, 0);
        issue(1'b0, 1'b1, 5'd31, 2'b10, 32'h77, 32'h0040_0010, 32'd0, 32'd0, 0);
        issue(1'b0, 1'b1, 5'd0, 2'b00, 32'hABC, 32'd0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 200; i++) random_instr();
        drain();

        // Reset during the second WAIT cycle of a load
        mux_wdata_MEM = 2'b01; write_MEM = 1'b1; waddr_MEM = 5'd4; alu_MEM = 32'h300;
        dm_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rstw_dm_req", 32'(dm_req), 32'd0);
        check("rstw_stall_o", 32'(stall_o), 32'd0);
        check("rstw_write_WB", 32'(write_WB), 32'd0);
        check("rstw_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        set_bubble();
        rst = 1'b1;
        m_waddr = 5'd0; m_wdata = 32'd0; m_eaddr = 32'd0; m_stalls = 32'd0;
        @(posedge clk); #1;
        check("post_rst_dm_req", 32'(dm_req), 32'd0);
        check("post_rst_stall_o", 32'(stall_o), 32'd0);
        mon_en = 1'b1;
        issue(1'b0, 1'b1, 5'd12, 2'b01, 32'h404, 32'd0, 32'd0, 32'hCAFE_F00D, 1);
        issue(1'b0, 1'b1, 5'd13, 2'b00, 32'h99, 32'd0, 32'd0, 32'd0, 0);
        drain();

`ifdef MEM_TIMEOUT_EN
        mux_wdata_MEM = 2'b01; write_MEM = 1'b1; waddr_MEM = 5'd9; alu_MEM = 32'h400;
        dm_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("to_stall_o", 32'(stall_o), 32'd1);
            @(posedge clk); #1;
        end
        dm_ack = 1'b1;
        #1;
        check("to_abort_dm_req", 32'(dm_req), 32'd0);
        check("to_abort_stall_o", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        check("timeout_err", 32'(timeout_err), 32'd1);
        check("to_write_WB", 32'(write_WB), 32'd0);
        check("to_err_addr", err_addr, 32'h400);
        set_bubble();
        @(posedge clk); #1;
        check("timeout_err_pulse", 32'(timeout_err), 32'd0);
        check("to_stall_cnt", stall_cnt, m_stalls + 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
